player_overlay: RTL and testbench
=================================

PLAYER_OVERLAY -- requirements
Module: player_overlay

Interface
REQ-001 Parameter PLAYER_SIZE, default 8: side in pixels of the square player sprite.
REQ-002 Parameter STEP, default 2: pixels moved per frame per held direction.
REQ-003 Parameter START_X, default 16: player top-left column after reset or respawn.
REQ-004 Parameter START_Y, default 236: player top-left row after reset or respawn.
REQ-005 Parameter HIT_FRAMES, default 60: frames spent in HIT before respawn.
REQ-006 pixel_clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 resetSwitch  input  1  reset, asynchronous, active-low.
REQ-008 col  input  10  current pixel column from the timing generator.
REQ-009 row  input  9  current pixel row from the timing generator.
REQ-010 lvl_red, lvl_green, lvl_blue  input  4 each  level colour from the upstream level renderer, valid one cycle after the col/row it belongs to.
REQ-011 btn_up, btn_down, btn_left, btn_right  input  1 each  active-high, level-held direction buttons.
REQ-012 red, green, blue  output  4 each  final pixel colour to the VGA DAC.
REQ-013 game_state  output  2  0 = PLAY, 1 = HIT, 2 = WIN.
REQ-014 deaths  output  8  count of wall hits, saturating at 255.

Function
REQ-015 The block SHALL delay col/row by one register stage so they align with lvl_*; red/green/blue SHALL be registered, for a total latency of 2 cycles from col/row.
REQ-016 An aligned pixel SHALL be active only when col < 640 and row < 480; inactive pixels SHALL output 0/0/0.
REQ-017 A pixel SHALL be in-sprite when px <= col < px+PLAYER_SIZE and py <= row < py+PLAYER_SIZE.
REQ-018 In-sprite colour SHALL be PLAY 0/0/F, HIT F/0/0, WIN F/F/0; all other active pixels SHALL pass lvl_* unchanged.
REQ-019 During a frame, an in-sprite active pixel with lvl colour 0/0/0 SHALL set wall_flag; one with lvl colour F/0/0 SHALL set finish_flag.
REQ-020 The frame tick SHALL be the cycle after the aligned pixel (639,479); both flags SHALL be consumed and cleared on the tick.
REQ-021 On the tick in PLAY: if finish_flag, go to WIN; else if wall_flag, go to HIT and increment deaths; else apply movement. Finish SHALL take priority over wall.
REQ-022 Movement: each held button SHALL move the player STEP pixels.
REQ-023 If up and down are held together, the vertical axis SHALL not move; left and right held together SHALL likewise cancel horizontally.
REQ-024 Position SHALL clamp to 0..640-PLAYER_SIZE in x and 0..480-PLAYER_SIZE in y, with no wrap-around.
REQ-025 In HIT, a frame counter SHALL increment on each tick; on reaching HIT_FRAMES it SHALL reset to START_X/START_Y, clear the counter and return to PLAY. Buttons SHALL be ignored in HIT.
REQ-026 WIN SHALL be terminal until reset; buttons SHALL be ignored in WIN.
REQ-027 deaths SHALL hold at 255 on further hits.

Reset
REQ-028 Asserting resetSwitch low SHALL immediately, regardless of clock, set:
- red/green/blue = 0
- game_state = PLAY
- deaths = 0
- position = START_X/START_Y
- flags, HIT counter and alignment registers cleared.
REQ-029 Reset mid-frame SHALL discard any partial collision flags; evaluation SHALL resume at the next full frame tick.

Configuration
REQ-030 With macro BTN_SYNC_EN defined, each button SHALL pass through a 2-flop synchronizer before use.
REQ-031 Without BTN_SYNC_EN, buttons SHALL be sampled directly; frame-level behaviour SHALL be identical in both builds.

Structure
REQ-032 Shared package maze_pkg SHALL hold:
- game_state_t enum (ST_PLAY, ST_HIT, ST_WIN)
- colour constants COL_WALL = 12'h000 and COL_FINISH = 12'hF00
- H_ACTIVE = 640 and V_ACTIVE = 480
REQ-033 Sub-module btn_sync (4-bit, 2-flop synchronizer) SHALL be instantiated only under BTN_SYNC_EN.

Verification
REQ-034 Reset, then idle 1 frame with lvl all F/F/F -> game_state=0; sprite 0/0/F at cols 16..23, rows 236..243; outputs match lvl_* two cycles later elsewhere.
REQ-035 Hold btn_right for 10 frames over an all-white level -> px=36, py=236; with right+left held together -> px unchanged.
REQ-036 Hold btn_left from px=0 for 3 frames -> px stays 0; hold btn_down to bottom -> py settles at 472.
REQ-037 lvl 0/0/0 at pixel (20,240) -> after the tick game_state=1, deaths=1, sprite red; after 60 ticks -> game_state=0, position 16/236.
REQ-038 Same frame sees wall and finish in-sprite -> game_state=2, deaths unchanged; buttons are then ignored.
REQ-039 Pull resetSwitch low mid-frame while in HIT with deaths=5 -> outputs 0 and state PLAY, deaths 0 and position 16/236 immediately, with no clock edge needed.

Source files
------------

// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
// Shared types and constants for the maze player overlay.
//   game_state_t  : ST_PLAY / ST_HIT / ST_WIN, encoded 0 / 1 / 2 on game_state
//   COL_WALL      : level colour that counts as a wall   (black)
//   COL_FINISH    : level colour that counts as the goal (red)
//   H_ACTIVE      : visible columns per line
//   V_ACTIVE      : visible rows per frame
//   sprite_colour : sprite fill colour for a given game state
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package maze_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HIT  = 2'd1,
    ST_WIN  = 2'd2
  } game_state_t;

  localparam logic [11:0] COL_WALL   = 12'h000;
  localparam logic [11:0] COL_FINISH = 12'hF00;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Colours are packed {red, green, blue}, 4 bits each.
  function automatic logic [11:0] sprite_colour(input game_state_t st);
    logic [11:0] c;
    c = 12'h00F;
    case (st)
      ST_HIT:  c = 12'hF00;
      ST_WIN:  c = 12'hFF0;
      default: c = 12'h00F;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// -----------------------------------------------------------------------------
// btn_sync
// Two-flop synchronizer for the four direction buttons. Only instantiated by
// player_overlay when BTN_SYNC_EN is defined.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears both stages
//   d_i    : asynchronous button levels {up, down, left, right}
//   q_o    : synchronized button levels, two clocks behind d_i
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module btn_sync (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/player_overlay.sv
// -----------------------------------------------------------------------------
// player_overlay
// Draws a square player sprite on top of the level image, detects wall/finish
// collisions per frame and runs the PLAY / HIT / WIN game state machine.
//
// Ports
//   pixel_clk                    : sole clock
//   resetSwitch                  : asynchronous active-low reset
//   col, row                     : pixel coordinate from the timing generator
//   lvl_red/green/blue           : level colour, one cycle behind col/row
//   btn_up/down/left/right       : level-held direction buttons, active high
//   red, green, blue             : final pixel colour, two cycles behind col/row
//   game_state                   : FSM state (0 PLAY, 1 HIT, 2 WIN), also the
//                                  state debug view
//   deaths                       : wall hit count, saturating at 255
//
// Timing contract: there is no handshake; col/row are registered once so they
// line up with lvl_*, and the composed colour is registered once more.
//
// Build option: define BTN_SYNC_EN to pass the buttons through a 2-flop
// synchronizer (btn_sync). Frame-level behaviour is the same either way.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module player_overlay
  import maze_pkg::*;
#(
  parameter int PLAYER_SIZE = 8,
  parameter int STEP        = 2,
  parameter int START_X     = 16,
  parameter int START_Y     = 236,
  parameter int HIT_FRAMES  = 60
) (
  input  logic       pixel_clk,
  input  logic       resetSwitch,
  input  logic [9:0] col,
  input  logic [8:0] row,
  input  logic [3:0] lvl_red,
  input  logic [3:0] lvl_green,
  input  logic [3:0] lvl_blue,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic [1:0] game_state,
  output logic [7:0] deaths
);

  localparam int X_MAX = H_ACTIVE - PLAYER_SIZE;
  localparam int Y_MAX = V_ACTIVE - PLAYER_SIZE;
  localparam int CNT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

  // Buttons packed {up, down, left, right}
  logic [3:0] btn;

`ifdef BTN_SYNC_EN
  btn_sync u_btn_sync (
    .clk_i  (pixel_clk),
    .rst_ni (resetSwitch),
    .d_i    ({btn_up, btn_down, btn_left, btn_right}),
    .q_o    (btn)
  );
`else
  assign btn = {btn_up, btn_down, btn_left, btn_right};
`endif

  logic [9:0]       col_q;
  logic [8:0]       row_q;
  logic             eof_q;
  logic             wall_q;
  logic             fin_q;
  game_state_t      state_q;
  logic [9:0]       px_q;
  logic [8:0]       py_q;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [7:0]       deaths_q;
  logic [11:0]      rgb_q;

  logic [11:0] lvl_rgb;
  logic        active;
  logic        in_sprite;
  logic        eof_d;
  logic        wall_d;
  logic        fin_d;
  logic [11:0] rgb_d;
  logic [9:0]  px_d;
  logic [8:0]  py_d;

  assign lvl_rgb = {lvl_red, lvl_green, lvl_blue};
  assign active  = (col_q < 10'(H_ACTIVE)) && (row_q < 9'(V_ACTIVE));

  // Upper bounds compared one bit wider so px+PLAYER_SIZE cannot overflow.
  assign in_sprite = (col_q >= px_q) && ({1'b0, col_q} < ({1'b0, px_q} + 11'(PLAYER_SIZE)))
                  && (row_q >= py_q) && ({1'b0, row_q} < ({1'b0, py_q} + 10'(PLAYER_SIZE)));

  assign eof_d = (col_q == 10'(H_ACTIVE - 1)) && (row_q == 9'(V_ACTIVE - 1));

  // eof_q marks the frame tick. The pixel aligned during the tick cycle
  // already belongs to the next frame, so it may re-set a flag being cleared.
  assign wall_d = (eof_q ? 1'b0 : wall_q) | (active && in_sprite && (lvl_rgb == COL_WALL));
  assign fin_d  = (eof_q ? 1'b0 : fin_q)  | (active && in_sprite && (lvl_rgb == COL_FINISH));

  always_comb begin
    rgb_d = 12'h000;
    if (active) begin
      rgb_d = in_sprite ? sprite_colour(state_q) : lvl_rgb;
    end
  end

  // Opposite buttons cancel; each axis clamps without wrapping.
  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (btn[0] && !btn[1]) begin
      px_d = (px_q >= 10'(X_MAX - STEP)) ? 10'(X_MAX) : px_q + 10'(STEP);
    end else if (btn[1] && !btn[0]) begin
      px_d = (px_q < 10'(STEP)) ? 10'd0 : px_q - 10'(STEP);
    end
    if (btn[2] && !btn[3]) begin
      py_d = (py_q >= 9'(Y_MAX - STEP)) ? 9'(Y_MAX) : py_q + 9'(STEP);
    end else if (btn[3] && !btn[2]) begin
      py_d = (py_q < 9'(STEP)) ? 9'd0 : py_q - 9'(STEP);
    end
  end

  always_ff @(posedge pixel_clk or negedge resetSwitch) begin
    if (!resetSwitch) begin
      col_q     <= '0;
      row_q     <= '0;
      eof_q     <= 1'b0;
      wall_q    <= 1'b0;
      fin_q     <= 1'b0;
      state_q   <= ST_PLAY;
      px_q      <= 10'(START_X);
      py_q      <= 9'(START_Y);
      hit_cnt_q <= '0;
      deaths_q  <= '0;
      rgb_q     <= '0;
    end else begin
      col_q  <= col;
      row_q  <= row;
      eof_q  <= eof_d;
      wall_q <= wall_d;
      fin_q  <= fin_d;
      rgb_q  <= rgb_d;
      if (eof_q) begin
        case (state_q)
          ST_PLAY: begin
            // Reaching the goal wins even if a wall was touched that frame.
            if (fin_q) begin
              state_q <= ST_WIN;
            end else if (wall_q) begin
              state_q <= ST_HIT;
              if (deaths_q != 8'hFF) deaths_q <= deaths_q + 8'd1;
            end else begin
              px_q <= px_d;
              py_q <= py_d;
            end
          end
          ST_HIT: begin
            if (hit_cnt_q == CNT_W'(HIT_FRAMES - 1)) begin
              hit_cnt_q <= '0;
              px_q      <= 10'(START_X);
              py_q      <= 9'(START_Y);
              state_q   <= ST_PLAY;
            end else begin
              hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end
          end
          default: begin
            // WIN holds until reset.
          end
        endcase
      end
    end
  end

  assign red        = rgb_q[11:8];
  assign green      = rgb_q[7:4];
  assign blue       = rgb_q[3:0];
  assign game_state = state_q;
  assign deaths     = deaths_q;

endmodule

// File: tb/tb_player_overlay.sv
// -----------------------------------------------------------------------------
// tb_player_overlay
// Drives compressed frames (only the pixels around the sprite plus the final
// pixel 639,479) and compares every rendered pixel, the game state and the
// death count against a frame-level model of the game rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_player_overlay;

  localparam int S    = 8;
  localparam int STEP = 2;
  localparam int SX   = 16;
  localparam int SY   = 236;
  localparam int HF   = 60;

  // ---------------- clock / reset / DUT ----------------
  logic       pixel_clk   = 1'b0;
  logic       resetSwitch = 1'b1;
  logic [9:0] col         = '0;
  logic [8:0] row         = '0;
  logic [3:0] lvl_red     = '0;
  logic [3:0] lvl_green   = '0;
  logic [3:0] lvl_blue    = '0;
  logic       btn_up      = 1'b0;
  logic       btn_down    = 1'b0;
  logic       btn_left    = 1'b0;
  logic       btn_right   = 1'b0;
  logic [3:0] red, green, blue;
  logic [1:0] game_state;
  logic [7:0] deaths;

  always #5 pixel_clk = ~pixel_clk;

  player_overlay dut (
    .pixel_clk   (pixel_clk),
    .resetSwitch (resetSwitch),
    .col         (col),
    .row         (row),
    .lvl_red     (lvl_red),
    .lvl_green   (lvl_green),
    .lvl_blue    (lvl_blue),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .game_state  (game_state),
    .deaths      (deaths)
  );

  // ---------------- reference model state ----------------
  int  checks   = 0;
  int  failures = 0;
  int  m_px, m_py, m_st, m_deaths, m_cnt;
  bit  m_wall, m_fin;
  logic [12:0] exp_q[$];     // {valid, expected rgb}, two-cycle pipeline
  logic [11:0] prev_lvl = '0;
  int  wall_c = -1, wall_r = -1, fin_c = -1, fin_r = -1;
  bit  rand_lvl = 1'b0;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [11:0] lvl_at(input int c, input int r);
    int k;
    if (c == wall_c && r == wall_r) return 12'h000;
    if (c == fin_c && r == fin_r) return 12'hF00;
    if (c >= 640 || r >= 480) return 12'h000;
    if (rand_lvl) begin
      k = $urandom_range(0, 7);
      if (k == 0) return 12'h000;
      if (k < 4) return 12'($urandom);
    end
    return 12'hFFF;
  endfunction

  task automatic model_reset();
    m_px = SX; m_py = SY; m_st = 0; m_deaths = 0; m_cnt = 0;
    m_wall = 0; m_fin = 0;
  endtask

  task automatic model_tick();
    int dx, dy;
    case (m_st)
      0: begin
        if (m_fin) m_st = 2;
        else if (m_wall) begin
          m_st = 1;
          if (m_deaths < 255) m_deaths++;
        end else begin
          dx = (btn_right ? STEP : 0) - (btn_left ? STEP : 0);
          dy = (btn_down ? STEP : 0) - (btn_up ? STEP : 0);
          m_px = clampi(m_px + dx, 0, 640 - S);
          m_py = clampi(m_py + dy, 0, 480 - S);
        end
      end
      1: begin
        m_cnt++;
        if (m_cnt == HF) begin
          m_cnt = 0; m_px = SX; m_py = SY; m_st = 0;
        end
      end
      default: ;
    endcase
    m_wall = 0;
    m_fin  = 0;
  endtask

  // ---------------- driver tasks ----------------
  // One pixel per cycle: col/row now, its level colour one cycle later,
  // its output checked two cycles later.
  task automatic cyc(input int c, input int r, input logic [11:0] l);
    logic [12:0] e;
    logic [11:0] ex;
    @(negedge pixel_clk);
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      if (e[12]) check("pixel", {red, green, blue}, e[11:0]);
    end
    col = 10'(c);
    row = 9'(r);
    {lvl_red, lvl_green, lvl_blue} = prev_lvl;
    prev_lvl = l;
    if (c >= 640 || r >= 480) ex = 12'h000;
    else if (c >= m_px && c < m_px + S && r >= m_py && r < m_py + S) begin
      ex = (m_st == 0) ? 12'h00F : (m_st == 1) ? 12'hF00 : 12'hFF0;
      if (l == 12'h000) m_wall = 1;
      if (l == 12'hF00) m_fin  = 1;
    end else ex = l;
    exp_q.push_back({1'b1, ex});
  endtask

  task automatic frame_end();
    cyc(639, 479, lvl_at(639, 479));
    model_tick();
    repeat (3) cyc(700, 500, 12'h000);
  endtask

  task automatic run_frame(input bit scan);
    int px0, py0;
    px0 = m_px;
    py0 = m_py;
    if (scan) begin
      for (int r = py0 - 1; r <= py0 + S; r++)
        if (r >= 0)
          for (int c = px0 - 1; c <= px0 + S; c++)
            if (c >= 0) cyc(c, r, lvl_at(c, r));
    end else begin
      repeat (3) cyc(700, 500, 12'h000);
    end
    frame_end();
  endtask

  task automatic status();
    cyc(700, 500, 12'h000);
    check("game_state", 12'(game_state), 12'(m_st));
    check("deaths", 12'(deaths), 12'(m_deaths));
  endtask

  task automatic set_btn(input bit u, input bit d, input bit l, input bit r);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
  endtask

  // Reset lands between clock edges and is checked before the next edge.
  task automatic do_reset();
    @(negedge pixel_clk);
    #2 resetSwitch = 1'b0;
    #1;
    check("rst_rgb", {red, green, blue}, 12'h000);
    check("rst_state", 12'(game_state), 12'h000);
    check("rst_deaths", 12'(deaths), 12'h000);
    model_reset();
    exp_q.delete();
    prev_lvl = '0;
    wall_c = -1; wall_r = -1; fin_c = -1; fin_r = -1;
    set_btn(0, 0, 0, 0);
    repeat (2) @(negedge pixel_clk);
    resetSwitch = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    do_reset();

    // Idle frame, white level: blue sprite at 16..23 / 236..243
    run_frame(1);
    status();

    // Right for 10 frames -> x 36
    set_btn(0, 0, 0, 1);
    repeat (10) run_frame(0);
    set_btn(0, 0, 0, 0);
    run_frame(1);

    // Left and right together cancel
    set_btn(0, 0, 1, 1);
    repeat (2) run_frame(0);
    set_btn(0, 0, 0, 0);
    run_frame(1);

    // Left to the edge and beyond
    set_btn(0, 0, 1, 0);
    repeat (21) run_frame(0);
    set_btn(0, 0, 0, 0);
    run_frame(1);

    // Down to the bottom edge (472)
    set_btn(0, 1, 0, 0);
    repeat (120) run_frame(0);
    set_btn(0, 0, 0, 0);
    run_frame(1);

    // Right to the right edge (632); sprite then covers pixel 639,479
    set_btn(0, 0, 0, 1);
    repeat (320) run_frame(0);
    set_btn(0, 0, 0, 0);
    run_frame(1);

    // Up and down together cancel
    set_btn(1, 1, 0, 0);
    repeat (2) run_frame(0);
    set_btn(0, 0, 0, 0);
    run_frame(1);
    status();

    // Wall at (20,240) -> HIT, then respawn after 60 ticks
    do_reset();
    wall_c = 20; wall_r = 240;
    run_frame(1);
    wall_c = -1; wall_r = -1;
    status();
    set_btn(0, 0, 0, 1);
    run_frame(1);
    repeat (58) run_frame(0);
    status();
    run_frame(0);
    set_btn(0, 0, 0, 0);
    status();
    run_frame(1);

    // Four more hits -> deaths 5, left in HIT
    for (int i = 0; i < 4; i++) begin
      wall_c = m_px + 2; wall_r = m_py + 2;
      run_frame(1);
      wall_c = -1; wall_r = -1;
      status();
      if (i < 3) repeat (HF) run_frame(0);
    end
    status();

    // Partial frame with a wall pixel, then reset mid-frame
    wall_c = m_px; wall_r = m_py;
    for (int c = m_px - 1; c < m_px + 12; c++) cyc(c, m_py, lvl_at(c, m_py));
    do_reset();
    run_frame(1);
    status();
    set_btn(0, 1, 0, 1);
    run_frame(1);
    set_btn(0, 0, 0, 0);
    run_frame(1);
    status();

    // Random buttons and random level colours around the sprite
    rand_lvl = 1'b1;
    for (int i = 0; i < 25; i++) begin
      set_btn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      run_frame(1);
      status();
    end
    rand_lvl = 1'b0;

    // Wall and finish in the same frame -> WIN, deaths unchanged
    do_reset();
    wall_c = 17; wall_r = 237;
    fin_c  = 18; fin_r  = 238;
    run_frame(1);
    wall_c = -1; wall_r = -1; fin_c = -1; fin_r = -1;
    status();
    set_btn(0, 1, 0, 1);
    repeat (3) run_frame(1);
    set_btn(0, 0, 0, 0);
    status();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
